product_serial_rx: RTL and testbench
====================================

PRODUCT_SERIAL_RX -- requirements
Module: product_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, meaning CLK cycles per serial bit period; legal range 1..255.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx  input  1  serial line from the multiplier transmitter, same clock domain, idle-high; sampled directly, no synchronizer.
REQ-005 prod_ready  input  1  consumer accepts the presented product this cycle.
REQ-006 product  output  8  signed received product, two's complement, bit0 = first data bit received.
REQ-007 prod_valid  output  1  product holds an unconsumed word.
REQ-008 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 overrun  output  1  one-cycle pulse when a good frame is dropped for lack of storage.

Function
REQ-010 Frame format SHALL be start bit 0, eight data bits LSB first, stop bit 1; frames may arrive back-to-back, with the next start bit in the bit period right after the stop bit.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, RESYNC.
REQ-012 IDLE: rx==0 -> START and load bit timer with CLKS_PER_BIT/2 (integer division); rx==1 -> stay.
REQ-013 START: when timer reaches 0, sample rx; 0 -> DATA, bit timer = CLKS_PER_BIT, bit count = 0; 1 -> IDLE (false start, no flags). If CLKS_PER_BIT/2==0, the start bit is confirmed in the detection cycle, so IDLE goes directly to DATA.
REQ-014 DATA: on each timer expiry, shift rx into bit position [bit count]; after the 8th bit -> STOP.
REQ-015 STOP: on timer expiry, sample rx; 1 -> push shifted word to storage and go to IDLE; 0 -> frame_err pulse, discard word, go to RESYNC.
REQ-016 RESYNC: remain until rx==1, then go to IDLE.
REQ-017 Latency: a pushed word SHALL appear on product with prod_valid=1 in the cycle after the edge that sampled the stop bit.
REQ-018 Handshake: a word is consumed on a rising edge with prod_valid && prod_ready; product SHALL be stable while prod_valid && !prod_ready.
REQ-019 Push into full storage SHALL drop the new word and pulse overrun; stored contents are unchanged.
REQ-020 A push and a pop in the same cycle on full storage SHALL both succeed with no overrun.
REQ-021 frame_err and overrun SHALL each be high for exactly one cycle per event.

Reset
REQ-022 On rst: FSM = IDLE, timers, bit count, shift register and storage cleared; product=8'h00, prod_valid=0, frame_err=0, overrun=0.
REQ-023 Reset mid-frame SHALL abandon the partial frame with no flag; reception restarts at the next falling rx after release.

Configuration
REQ-024 Macro PRODUCT_RX_FIFO_EN defined: storage SHALL be a 4-entry first-word-fall-through FIFO; product shows the head entry; full = 4 entries.
REQ-025 Macro PRODUCT_RX_FIFO_EN undefined: storage SHALL be a single holding register; full = prod_valid.

Verification
REQ-026 CLKS_PER_BIT=1, prod_ready=1, rx = 0,0,0,1,0,1,1,1,1,1 -> product=8'hF4 (-12), prod_valid high exactly one cycle after the stop sample, no flags.
REQ-027 Back-to-back frames 8'h15 then 8'h80, prod_ready=1 -> prod_valid pulses 10 cycles apart with product 8'h15 then 8'h80.
REQ-028 Frame 8'h3C with stop bit 0, then rx=1 for 2 cycles, then frame 8'h07 -> frame_err pulse once; only 8'h07 is delivered.
REQ-029 prod_ready=0 with 5 good frames 8'h01..8'h05 -> without FIFO: 8'h01 held and 4 overrun pulses; with FIFO: 8'h01..8'h04 are held and 1 overrun pulse; then prod_ready=1 drains the held words in order.
REQ-030 Assert rst after 4 data bits of a frame -> all outputs 0, no flags; the next full frame 8'hA5 is received correctly.
REQ-031 CLKS_PER_BIT=4, rx low for 1 cycle -> no start (returns to IDLE); a full 4x-stretched frame 8'h9C -> product=8'h9C.

Source files
------------

// File: rtl/product_serial_rx.sv
// Serial receiver for 8-bit signed products: start/8 data LSB-first/stop framing, output handshake.
// Define PRODUCT_RX_FIFO_EN for a 4-entry FWFT output FIFO; otherwise a single holding register.
module product_serial_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       rx,
  input  logic       prod_ready,
  output logic [7:0] product,
  output logic       prod_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [7:0] BIT_TICKS  = 8'(CLKS_PER_BIT);
  localparam logic [7:0] HALF_TICKS = 8'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RESYNC
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  timer, timer_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shift, shift_nx;
  logic        tick;
  logic        push;
  logic        ferr;
  logic        pop;
  logic        full;
  logic        accept;
  logic        drop;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
    end
  end

  // The sample is taken in the cycle where the timer would count down to zero.
  assign tick = (timer == 8'd1);

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    push       = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          if (HALF_TICKS == '0) begin
            state_nx   = DATA;
            timer_nx   = BIT_TICKS;
            bit_cnt_nx = '0;
          end else begin
            state_nx = START;
            timer_nx = HALF_TICKS;
          end
        end
      end
      START: begin
        if (tick) begin
          if (!rx) begin
            state_nx   = DATA;
            timer_nx   = BIT_TICKS;
            bit_cnt_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nx[bit_cnt] = rx;
          timer_nx          = BIT_TICKS;
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx) begin
            push     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = RESYNC;
          end
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      RESYNC: begin
        if (rx) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop    = prod_valid && prod_ready;
  // A pop in the same cycle frees the slot, so a full store can still accept.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= drop;
    end
  end

`ifdef PRODUCT_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;

  assign full       = (count == 3'd4);
  assign prod_valid = (count != 3'd0);
  assign product    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + 3'(accept) - 3'(pop);
    end
  end
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign full       = hold_valid;
  assign prod_valid = hold_valid;
  assign product    = hold;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        hold       <= shift;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_product_serial_rx.sv
// Scoreboard bench for product_serial_rx: two instances (1 and 4 clocks per bit) vs a frame-level model.
module tb_product_serial_rx;

  localparam int CPB0 = 1;
  localparam int CPB1 = 4;
`ifdef PRODUCT_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] prod0, prod1;
  logic       pv0, pv1, fe0, fe1, ov0, ov1;

  always #5 clk = ~clk;

  product_serial_rx #(.CLKS_PER_BIT(CPB0)) u_rx0 (
    .CLK(clk), .rst(rst), .rx(rx0), .prod_ready(rdy0),
    .product(prod0), .prod_valid(pv0), .frame_err(fe0), .overrun(ov0)
  );

  product_serial_rx #(.CLKS_PER_BIT(CPB1)) u_rx1 (
    .CLK(clk), .rst(rst), .rx(rx1), .prod_ready(rdy1),
    .product(prod1), .prod_valid(pv1), .frame_err(fe1), .overrun(ov1)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         occ[2];
  bit         exp_fe[2], exp_ov[2];
  logic [7:0] q0[$], q1[$];
  bit         pend_on[2], pend_good[2];
  int         pend_cyc[2];
  logic [7:0] pend_val[2];
  int         fe_seen[2], ov_seen[2];
  int         pop_cyc0[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void q_push(input int k, input logic [7:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_drop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  // Frame-level model: a completed frame lands in bounded storage when its stop bit is sampled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        occ[k] = 0; exp_fe[k] = 0; exp_ov[k] = 0; pend_on[k] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit pop;
        pop = (occ[k] > 0) && ((k == 0) ? rdy0 : rdy1);
        exp_fe[k] = 0;
        exp_ov[k] = 0;
        if (pend_on[k] && pend_cyc[k] == cyc) begin
          pend_on[k] = 0;
          if (!pend_good[k]) exp_fe[k] = 1;
          else if (occ[k] < CAP || pop) begin
            q_push(k, pend_val[k]);
            occ[k]++;
          end else exp_ov[k] = 1;
        end
        if (pop) occ[k]--;
      end
      cyc++;
    end
  end

  task automatic mon(input int k, input logic v, input logic [7:0] p, input logic fe,
                     input logic ov, input logic rdy);
    check($sformatf("valid%0d", k), v, occ[k] > 0);
    if (v === 1'b1) begin
      if (q_size(k) == 0) begin
        checks++;
        errors++;
        $display("FAIL product%0d: got %0h expected no word (cycle %0d)", k, p, cyc);
      end else begin
        check($sformatf("product%0d", k), p, q_front(k));
        if (rdy) begin
          q_drop(k);
          if (k == 0) pop_cyc0.push_back(cyc);
        end
      end
    end
    check($sformatf("frame_err%0d", k), fe, exp_fe[k]);
    check($sformatf("overrun%0d", k), ov, exp_ov[k]);
    if (fe === 1'b1) fe_seen[k]++;
    if (ov === 1'b1) ov_seen[k]++;
  endtask

  always @(negedge clk) begin
    mon(0, pv0, prod0, fe0, ov0, rdy0);
    mon(1, pv1, prod1, fe1, ov1, rdy1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int k, input logic v);
    if (k == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic idle(input int k, input int n);
    set_rx(k, 1'b1);
    tick(n);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input bit good);
    int cpb;
    cpb = (k == 0) ? CPB0 : CPB1;
    pend_cyc[k]  = cyc + cpb / 2 + 9 * cpb;
    pend_val[k]  = d;
    pend_good[k] = good;
    pend_on[k]   = 1;
    set_rx(k, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      set_rx(k, d[i]);
      tick(cpb);
    end
    set_rx(k, good);
    tick(cpb);
  endtask

  initial begin
    int base;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    @(negedge clk);
    check("rst_product0", prod0, 8'h00);
    check("rst_product1", prod1, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // -12 as a single frame, consumed immediately
    rdy0 = 1'b1;
    base = fe_seen[0] + ov_seen[0];
    send_frame(0, 8'hF4, 1'b1);
    idle(0, 3);
    check("f4_no_flags", fe_seen[0] + ov_seen[0], base);

    // back-to-back frames are delivered exactly one frame time apart
    pop_cyc0.delete();
    send_frame(0, 8'h15, 1'b1);
    send_frame(0, 8'h80, 1'b1);
    idle(0, 3);
    check("b2b_count", pop_cyc0.size(), 2);
    if (pop_cyc0.size() == 2) check("b2b_spacing", pop_cyc0[1] - pop_cyc0[0], 10);

    // bad stop bit: flagged once, word discarded, receiver resynchronises
    base = fe_seen[0];
    send_frame(0, 8'h3C, 1'b0);
    idle(0, 2);
    send_frame(0, 8'h07, 1'b1);
    idle(0, 3);
    check("ferr_count", fe_seen[0] - base, 1);

    // storage fill with consumer stalled, then drain in order
    rdy0 = 1'b0;
    base = ov_seen[0];
    for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b1);
    idle(0, 3);
    check("overrun_count", ov_seen[0] - base, (CAP == 4) ? 1 : 4);
    check("held_head", prod0, 8'h01);
    rdy0 = 1'b1;
    tick(8);
    check("drained0", q_size(0), 0);

    // reset in the middle of a frame
    set_rx(0, 1'b0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, i[0]);
      tick(1);
    end
    rst = 1'b1;
    set_rx(0, 1'b1);
    @(negedge clk);
    check("midrst_product", prod0, 8'h00);
    check("midrst_valid", pv0, 1'b0);
    check("midrst_flags", {fe0, ov0}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(0, 2);
    send_frame(0, 8'hA5, 1'b1);
    idle(0, 3);

    // slow line: glitch shorter than half a bit is ignored
    rdy1 = 1'b1;
    base = fe_seen[1] + ov_seen[1];
    set_rx(1, 1'b0);
    tick(1);
    idle(1, 8);
    check("glitch_flags", fe_seen[1] + ov_seen[1], base);
    send_frame(1, 8'h9C, 1'b1);
    idle(1, 4);
    check("drained1", q_size(1), 0);

    // randomized frames on both lines with varying consumer readiness
    for (int it = 0; it < 30; it++) begin
      int         k;
      logic [7:0] d;
      bit         good;
      k    = $urandom_range(0, 1);
      d    = 8'($urandom);
      good = ($urandom_range(0, 9) != 0);
      if (k == 0) rdy0 = ($urandom_range(0, 2) != 0); else rdy1 = ($urandom_range(0, 2) != 0);
      send_frame(k, d, good);
      idle(k, good ? $urandom_range(0, 3) : $urandom_range(1, 3));
    end
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rx0  = 1'b1;
    rx1  = 1'b1;
    tick(20);
    check("final_drain0", q_size(0), 0);
    check("final_drain1", q_size(1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
